// File: rtl/ysyx_23060201_idu_stage_pkg.sv
// Shared decode definitions for the ysyx_23060201 decode stage.
// Holds the RV32I base opcodes, the output format encoding, the EBREAK word,
// the decoded-packet struct and a register-index range check.
package ysyx_23060201_idu_stage_pkg;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [31:0] EbreakInst = 32'h0010_0073;

    // Format encoding seen by execute; FmtN covers SYSTEM and illegal words.
    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5,
        FmtN = 3'd6
    } fmt_e;

    // Decoded fields; register indices kept at full 5 bits, narrowed at the port.
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        rd_we;
        logic        ebreak;
        logic        illegal;
    } dec_t;

    // True when idx needs more bits than the register file provides (RV32E builds).
    function automatic logic reg_oob(logic [4:0] idx, int unsigned width);
        if (width >= 5) begin
            return 1'b0;
        end
        return (idx >> width) != 5'd0;
    endfunction

endpackage

// File: rtl/ysyx_23060201_imm_gen.sv
// Combinational RV32I format / immediate decoder.
// Ports:
//   inst_i    - instruction word
//   fmt_o     - instruction format (FmtN for SYSTEM or illegal)
//   imm_o     - sign-extended immediate, 0 for R/N formats
//   illegal_o - opcode outside the base set, or a used register index out of range
//   ebreak_o  - instruction is exactly EBREAK
module ysyx_23060201_imm_gen
    import ysyx_23060201_idu_stage_pkg::*;
#(
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic [31:0] inst_i,
    output fmt_e        fmt_o,
    output logic [31:0] imm_o,
    output logic        illegal_o,
    output logic        ebreak_o
);

    fmt_e fmt_raw;
    logic known;
    logic use_rd;
    logic use_rs1;
    logic use_rs2;
    logic oob;

    always_comb begin
        fmt_raw = FmtN;
        known   = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (inst_i[6:0])
            OpcOp: begin
                fmt_raw = FmtR;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpcOpImm, OpcLoad, OpcJalr: begin
                fmt_raw = FmtI;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OpcStore: begin
                fmt_raw = FmtS;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpcBranch: begin
                fmt_raw = FmtB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpcLui, OpcAuipc: begin
                fmt_raw = FmtU;
                use_rd  = 1'b1;
            end
            OpcJal: begin
                fmt_raw = FmtJ;
                use_rd  = 1'b1;
            end
            OpcSystem: fmt_raw = FmtN;
            default:   known   = 1'b0;
        endcase

        // Only indices the format actually uses can make the word illegal.
        oob = (use_rd  && reg_oob(inst_i[11:7],  RegAddrWidth)) ||
              (use_rs1 && reg_oob(inst_i[19:15], RegAddrWidth)) ||
              (use_rs2 && reg_oob(inst_i[24:20], RegAddrWidth));

        illegal_o = !known || oob;
        fmt_o     = illegal_o ? FmtN : fmt_raw;

        case (fmt_o)
            FmtI:    imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            FmtS:    imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FmtB:    imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                              inst_i[11:8], 1'b0};
            FmtU:    imm_o = {inst_i[31:12], 12'b0};
            FmtJ:    imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                              inst_i[30:21], 1'b0};
            default: imm_o = 32'd0;
        endcase

        ebreak_o = (inst_i == EbreakInst);
    end

endmodule

// File: rtl/ysyx_23060201_idu_stage.sv
// RV32I decode stage between fetch and execute.
// Decodes {pc, inst} on the input side and buffers decoded packets in an
// output register plus one skid register, giving full throughput under
// backpressure with in_ready depending only on registered state (and reset).
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   in_valid_i/in_ready_o     - fetch handshake; in_pc_i, in_inst_i payload
//   flush_i                   - redirect from execute, drops everything in flight
//   out_valid_o/out_ready_i   - execute handshake
//   out_pc_o, out_inst_o      - pass-through pc and instruction word
//   out_rs1_o/rs2_o/rd_o      - register indices
//   out_imm_o, out_fmt_o      - immediate and format
//   out_rd_we_o, out_ebreak_o, out_illegal_o - decode flags
module ysyx_23060201_idu_stage
    import ysyx_23060201_idu_stage_pkg::*;
#(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,  // must be at least 32
    parameter int unsigned RegAddrWidth = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [AddrWidth-1:0]    in_pc_i,
    input  logic [DataWidth-1:0]    in_inst_i,
    input  logic                    flush_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [AddrWidth-1:0]    out_pc_o,
    output logic [DataWidth-1:0]    out_inst_o,
    output logic [RegAddrWidth-1:0] out_rs1_o,
    output logic [RegAddrWidth-1:0] out_rs2_o,
    output logic [RegAddrWidth-1:0] out_rd_o,
    output logic [31:0]             out_imm_o,
    output logic [2:0]              out_fmt_o,
    output logic                    out_rd_we_o,
    output logic                    out_ebreak_o,
    output logic                    out_illegal_o
);

    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        logic [DataWidth-1:0] inst;
        dec_t                 dec;
    } pkt_t;

    fmt_e        in_fmt;
    logic [31:0] in_imm;
    logic        in_illegal;
    logic        in_ebreak;
    pkt_t        in_pkt;

    ysyx_23060201_imm_gen #(
        .RegAddrWidth (RegAddrWidth)
    ) u_imm_gen (
        .inst_i    (in_inst_i[31:0]),
        .fmt_o     (in_fmt),
        .imm_o     (in_imm),
        .illegal_o (in_illegal),
        .ebreak_o  (in_ebreak)
    );

    always_comb begin
        in_pkt             = '0;
        in_pkt.pc          = in_pc_i;
        in_pkt.inst        = in_inst_i;
        in_pkt.dec.rs1     = in_inst_i[19:15];
        in_pkt.dec.rs2     = in_inst_i[24:20];
        in_pkt.dec.rd      = in_inst_i[11:7];
        in_pkt.dec.imm     = in_imm;
        in_pkt.dec.fmt     = in_fmt;
        // Illegal words are already FmtN, so they never write rd.
        in_pkt.dec.rd_we   = (in_fmt inside {FmtR, FmtI, FmtU, FmtJ}) &&
                             (in_inst_i[11:7] != 5'd0);
        in_pkt.dec.ebreak  = in_ebreak;
        in_pkt.dec.illegal = in_illegal;
    end

    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    pkt_t out_pkt_q, out_pkt_d;
    pkt_t skid_pkt_q;
    logic out_load;
    logic skid_load;
    logic accept;
    logic consume;

    assign in_ready_o = !rst_i && !skid_valid_q;

    // A flush cycle neither accepts nor consumes.
    assign accept  = in_valid_i && in_ready_o && !flush_i;
    assign consume = out_valid_q && out_ready_i && !flush_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_load     = 1'b0;
        skid_load    = 1'b0;
        // Skid is older than anything on the input, so it drains first.
        out_pkt_d    = skid_valid_q ? skid_pkt_q : in_pkt;

        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_load     = 1'b1;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_load    = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_pkt_q    <= '0;
            skid_pkt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            if (out_load) begin
                out_pkt_q <= out_pkt_d;
            end
            if (skid_load) begin
                skid_pkt_q <= in_pkt;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = out_pkt_q.pc;
    assign out_inst_o    = out_pkt_q.inst;
    assign out_rs1_o     = out_pkt_q.dec.rs1[RegAddrWidth-1:0];
    assign out_rs2_o     = out_pkt_q.dec.rs2[RegAddrWidth-1:0];
    assign out_rd_o      = out_pkt_q.dec.rd[RegAddrWidth-1:0];
    assign out_imm_o     = out_pkt_q.dec.imm;
    assign out_fmt_o     = out_pkt_q.dec.fmt;
    assign out_rd_we_o   = out_pkt_q.dec.rd_we;
    assign out_ebreak_o  = out_pkt_q.dec.ebreak;
    assign out_illegal_o = out_pkt_q.dec.illegal;

endmodule

// File: tb/tb_ysyx_23060201_idu_stage.sv
// Self-checking bench for ysyx_23060201_idu_stage: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_ysyx_23060201_idu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_rd_we;
    logic        out_ebreak;
    logic        out_illegal;

    ysyx_23060201_idu_stage dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_pc_i       (in_pc),
        .in_inst_i     (in_inst),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_pc_o      (out_pc),
        .out_inst_o    (out_inst),
        .out_rs1_o     (out_rs1),
        .out_rs2_o     (out_rs2),
        .out_rd_o      (out_rd),
        .out_imm_o     (out_imm),
        .out_fmt_o     (out_fmt),
        .out_rd_we_o   (out_rd_we),
        .out_ebreak_o  (out_ebreak),
        .out_illegal_o (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  fmt;
        logic        rd_we;
        logic        ebreak;
        logic        illegal;
    } exp_t;

    exp_t q[$];     // packets held in the stage, oldest first
    exp_t shown;    // what the output register should currently hold
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode from the ISA field rules, using integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        int   f;
        int   imm;
        e      = '0;
        e.pc   = pc;
        e.inst = inst;
        e.rs1  = inst[19:15];
        e.rs2  = inst[24:20];
        e.rd   = inst[11:7];
        case (inst[6:0])
            7'h33:               f = 0;
            7'h13, 7'h03, 7'h67: f = 1;
            7'h23:               f = 2;
            7'h63:               f = 3;
            7'h37, 7'h17:        f = 4;
            7'h6f:               f = 5;
            7'h73:               f = 6;
            default:             f = 7;
        endcase
        e.illegal = (f == 7);
        if (f == 7) f = 6;
        imm = 0;
        case (f)
            1: begin
                imm = int'(32'(inst[31:20]));
                if (imm >= 2048) imm -= 4096;
            end
            2: begin
                imm = int'(32'(inst[31:25])) * 32 + int'(32'(inst[11:7]));
                if (imm >= 2048) imm -= 4096;
            end
            3: begin
                imm = int'(32'(inst[31])) * 4096 + int'(32'(inst[7])) * 2048
                    + int'(32'(inst[30:25])) * 32 + int'(32'(inst[11:8])) * 2;
                if (imm >= 4096) imm -= 8192;
            end
            4: imm = int'(32'(inst[31:12]) * 32'd4096);
            5: begin
                imm = int'(32'(inst[31])) * (1 << 20) + int'(32'(inst[19:12])) * 4096
                    + int'(32'(inst[20])) * 2048 + int'(32'(inst[30:21])) * 2;
                if (imm >= (1 << 20)) imm -= (1 << 21);
            end
            default: imm = 0;
        endcase
        e.imm    = 32'(imm);
        e.fmt    = 3'(f);
        e.rd_we  = (f == 0 || f == 1 || f == 4 || f == 5) && (inst[11:7] != 5'd0);
        e.ebreak = (inst == 32'h0010_0073);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0]  opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                   7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};
        logic [31:0] r = $urandom();
        logic [6:0]  o;
        int          s = $urandom_range(0, 12);
        if (s == 12) return 32'h0010_0073;
        if (s < 10) begin
            o = opcs[s];
        end else begin
            o = r[6:0];
            if (o == 7'h0F) o = 7'h7F;
        end
        return {r[31:7], o};
    endfunction

    // Advance the model with the inputs now driven, clock once, then compare.
    task automatic cycle();
        bit pop;
        bit acc;
        if (rst) begin
            q.delete();
            shown = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            pop = (q.size() > 0) && out_ready;
            acc = in_valid && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(in_pc, in_inst));
        end
        if (q.size() > 0) shown = q[0];
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(!rst && q.size() < 2));
        check("out_pc", out_pc, shown.pc);
        check("out_inst", out_inst, shown.inst);
        check("out_rs1", 32'(out_rs1), 32'(shown.rs1));
        check("out_rs2", 32'(out_rs2), 32'(shown.rs2));
        check("out_rd", 32'(out_rd), 32'(shown.rd));
        check("out_imm", out_imm, shown.imm);
        check("out_fmt", 32'(out_fmt), 32'(shown.fmt));
        check("out_rd_we", 32'(out_rd_we), 32'(shown.rd_we));
        check("out_ebreak", 32'(out_ebreak), 32'(shown.ebreak));
        check("out_illegal", 32'(out_illegal), 32'(shown.illegal));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    initial begin
        shown     = '0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        cycle();
        cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // Single-instruction decode examples.
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 32'h0050_0093);
        cycle();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_rd", 32'(out_rd), 32'd1);
        check("addi_imm", out_imm, 32'd5);
        check("addi_fmt", 32'(out_fmt), 32'd1);
        check("addi_rd_we", 32'(out_rd_we), 32'd1);
        drive(1'b1, 32'h8000_0004, 32'h1234_5137);
        cycle();
        check("lui_imm", out_imm, 32'h1234_5000);
        check("lui_fmt", 32'(out_fmt), 32'd4);
        check("lui_rd", 32'(out_rd), 32'd2);
        drive(1'b1, 32'h8000_0008, 32'hFFDF_F06F);
        cycle();
        check("jal_imm", out_imm, 32'hFFFF_FFFC);
        check("jal_fmt", 32'(out_fmt), 32'd5);
        check("jal_rd_we", 32'(out_rd_we), 32'd0);
        drive(1'b1, 32'h8000_000C, 32'h0010_0073);
        cycle();
        check("ebreak_flag", 32'(out_ebreak), 32'd1);
        check("ebreak_fmt", 32'(out_fmt), 32'd6);
        drive(1'b1, 32'h8000_0010, 32'hFFFF_FFFF);
        cycle();
        check("ill_flag", 32'(out_illegal), 32'd1);
        check("ill_rd_we", 32'(out_rd_we), 32'd0);
        drive(1'b0, 32'd0, 32'd0);
        cycle();

        // Backpressure: A, B fill the stage, C waits upstream, then all drain in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h0010_0113);
        cycle();
        drive(1'b1, 32'h104, 32'h0020_0193);
        cycle();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h108, 32'h0030_0213);
        cycle();
        cycle();
        check("bp_hold_a", out_pc, 32'h100);
        out_ready = 1'b1;
        cycle();
        check("bp_order_b", out_pc, 32'h104);
        cycle();
        check("bp_order_c", out_pc, 32'h108);
        drive(1'b0, 32'd0, 32'd0);
        cycle();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Flush with both entries full and C presented in the same cycle.
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'h0010_0113);
        cycle();
        drive(1'b1, 32'h204, 32'h0020_0193);
        cycle();
        drive(1'b1, 32'h208, 32'h0030_0213);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        cycle();
        cycle();

        // Reset mid-stream with both entries full.
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h0010_0113);
        cycle();
        drive(1'b1, 32'h304, 32'h0020_0193);
        cycle();
        rst = 1'b1;
        cycle();
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_pc", out_pc, 32'd0);
        check("mrst_imm", out_imm, 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        cycle();
        check("mrst_in_ready_after", 32'(in_ready), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_pc     = $urandom() & 32'hFFFF_FFFC;
            in_inst   = gen_inst();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
